// File: rtl/rv32_trap_ctrl.sv
// Machine-mode trap initiator: synchronises irq pins into mip, arbitrates exceptions,
// interrupts and mret, drains the pipe, then strobes a CSR trap commit and a PC redirect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | evaluate exc / enabled irq / mret each cycle
// FLUSH    | trap_req_o high, waiting for pipe_drained_i
// COMMIT   | trap_valid_o strobe with latched cause/epc
// REDIRECT | redirect to mtvec (base or vectored), trap_req_o still high
// RET      | mret redirect to mepc
module rv32_trap_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int MVU_IRQ_CODE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_i,
  input  logic        time_irq_i,
  input  logic        ipi_i,
  input  logic        mvu_irq_i,
  input  logic [31:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  input  logic [31:0] next_pc_i,
  input  logic        pipe_drained_i,
  output logic [31:0] mip_o,
  output logic        trap_req_o,
  output logic        trap_valid_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    COMMIT   = 3'd2,
    REDIRECT = 3'd3,
    RET      = 3'd4
  } state_t;

  state_t                       state;
  // chain bit order: 0 external, 1 timer, 2 software, 3 MVU
  logic [SYNC_STAGES-1:0][3:0]  sync_q;
  logic [3:0]                   synced;
  logic [31:0]                  enabled;
  logic [4:0]                   irq_code;
  logic [31:0]                  cause_q;
  logic [31:0]                  epc_q;
  logic                         is_irq_q;
  logic [31:0]                  tvec_base;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    mip_o               = '0;
    mip_o[11]           = synced[0];
    mip_o[7]            = synced[1];
    mip_o[3]            = synced[2];
    mip_o[MVU_IRQ_CODE] = synced[3];
  end

  assign enabled = mip_o & mie_i & {32{mstatus_mie_i}};

  always_comb begin
    irq_code = 5'd0;
    if (enabled[11])                irq_code = 5'd11;
    else if (enabled[3])            irq_code = 5'd3;
    else if (enabled[7])            irq_code = 5'd7;
    else if (enabled[MVU_IRQ_CODE]) irq_code = 5'(MVU_IRQ_CODE);
  end

  assign tvec_base = {mtvec_i[31:2], 2'b00};

  // mtvec is read live in REDIRECT so the CSR file's trap-time update is already visible
  always_comb begin
    redirect_pc_o = '0;
    if (state == REDIRECT) begin
      if (is_irq_q && mtvec_i[0]) redirect_pc_o = tvec_base + {cause_q[29:0], 2'b00};
      else                        redirect_pc_o = tvec_base;
    end else if (state == RET) begin
      redirect_pc_o = mepc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      sync_q           <= '0;
      cause_q          <= '0;
      epc_q            <= '0;
      is_irq_q         <= 1'b0;
      trap_req_o       <= 1'b0;
      trap_valid_o     <= 1'b0;
      redirect_valid_o <= 1'b0;
      cause_o          <= '0;
      epc_o            <= '0;
    end else begin
      sync_q           <= {sync_q[SYNC_STAGES-2:0], {mvu_irq_i, ipi_i, time_irq_i, irq_i}};
      trap_valid_o     <= 1'b0;
      redirect_valid_o <= 1'b0;
      cause_o          <= '0;
      epc_o            <= '0;
      case (state)
        IDLE: begin
          if (exc_valid_i) begin
            cause_q    <= exc_cause_i;
            epc_q      <= exc_pc_i;
            is_irq_q   <= 1'b0;
            trap_req_o <= 1'b1;
            state      <= FLUSH;
          end else if (|enabled) begin
            cause_q    <= {1'b1, 26'd0, irq_code};
            epc_q      <= next_pc_i;
            is_irq_q   <= 1'b1;
            trap_req_o <= 1'b1;
            state      <= FLUSH;
          end else if (mret_i) begin
            redirect_valid_o <= 1'b1;
            state            <= RET;
          end
        end
        FLUSH: begin
          if (pipe_drained_i) begin
            trap_valid_o <= 1'b1;
            cause_o      <= cause_q;
            epc_o        <= epc_q;
            state        <= COMMIT;
          end
        end
        COMMIT: begin
          redirect_valid_o <= 1'b1;
          state            <= REDIRECT;
        end
        REDIRECT: begin
          trap_req_o <= 1'b0;
          state      <= IDLE;
        end
        RET: begin
          state <= IDLE;
        end
        default: begin
          trap_req_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_trap_ctrl.sv
// Randomised bench for rv32_trap_ctrl against a transaction-level model of the trap rules.
module tb_rv32_trap_ctrl;
  localparam int MVU = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_i = 1'b0, time_irq_i = 1'b0, ipi_i = 1'b0, mvu_irq_i = 1'b0;
  logic [31:0] mie_i = '0;
  logic        mstatus_mie_i = 1'b0;
  logic [31:0] mtvec_i = '0, mepc_i = '0;
  logic        exc_valid_i = 1'b0;
  logic [31:0] exc_cause_i = '0, exc_pc_i = '0;
  logic        mret_i = 1'b0;
  logic [31:0] next_pc_i = '0;
  logic        pipe_drained_i = 1'b0;
  logic [31:0] mip_o;
  logic        trap_req_o, trap_valid_o, redirect_valid_o;
  logic [31:0] cause_o, epc_o, redirect_pc_o;

  int checks = 0;
  int failures = 0;
  logic [3:0] cur_pins = 4'b0;

  rv32_trap_ctrl #(.SYNC_STAGES(2), .MVU_IRQ_CODE(MVU)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .time_irq_i(time_irq_i), .ipi_i(ipi_i),
    .mvu_irq_i(mvu_irq_i), .mie_i(mie_i), .mstatus_mie_i(mstatus_mie_i), .mtvec_i(mtvec_i),
    .mepc_i(mepc_i), .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
    .mret_i(mret_i), .next_pc_i(next_pc_i), .pipe_drained_i(pipe_drained_i), .mip_o(mip_o),
    .trap_req_o(trap_req_o), .trap_valid_o(trap_valid_o), .cause_o(cause_o), .epc_o(epc_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // pins: [0] external, [1] timer, [2] software, [3] MVU
  function automatic logic [31:0] model_mip(input logic [3:0] pins);
    logic [31:0] m;
    m = '0;
    m[11]  = pins[0];
    m[7]   = pins[1];
    m[3]   = pins[2];
    m[MVU] = pins[3];
    return m;
  endfunction

  task automatic run_case(input string name, input logic [3:0] pins, input logic [31:0] mie,
                          input logic mstat, input logic exc, input logic [31:0] ecause,
                          input logic [31:0] epc, input logic mret, input logic [31:0] mtvec,
                          input logic [31:0] mtvec_late, input logic [31:0] mepc,
                          input logic [31:0] npc, input int d);
    int          prio[4];
    logic [31:0] m, exp_cause, exp_epc, exp_pc;
    int          kind, code;
    int          req_cnt, tv_cnt, rv_cnt, tv_at, rv_at;
    logic [31:0] got_cause, got_epc, got_pc;
    prio = '{11, 3, 7, MVU};
    @(negedge clk);
    irq_i = pins[0]; time_irq_i = pins[1]; ipi_i = pins[2]; mvu_irq_i = pins[3];
    mstatus_mie_i = 1'b0; exc_valid_i = 1'b0; mret_i = 1'b0; pipe_drained_i = 1'b0;
    mie_i = mie; mtvec_i = mtvec; mepc_i = mepc; next_pc_i = npc;
    @(negedge clk);
    chk({name, ".mip_lat1"}, mip_o, model_mip(cur_pins));
    @(negedge clk);
    m = model_mip(pins);
    chk({name, ".mip"}, mip_o, m);
    cur_pins = pins;

    kind = 0; code = -1;
    for (int i = 0; i < 4; i++)
      if (code < 0 && m[prio[i]] && mie[prio[i]] && mstat) code = prio[i];
    exp_cause = '0; exp_epc = '0; exp_pc = '0;
    if (exc) begin
      kind = 1; exp_cause = ecause; exp_epc = epc; exp_pc = {mtvec_late[31:2], 2'b00};
    end else if (code >= 0) begin
      kind = 1; exp_cause = 32'h8000_0000 | 32'(code); exp_epc = npc;
      exp_pc = {mtvec_late[31:2], 2'b00} + (mtvec_late[0] ? 32'(4 * code) : 32'd0);
    end else if (mret) begin
      kind = 2; exp_pc = mepc;
    end

    mstatus_mie_i = mstat; exc_valid_i = exc; exc_cause_i = ecause; exc_pc_i = epc; mret_i = mret;
    req_cnt = 0; tv_cnt = 0; rv_cnt = 0; tv_at = 0; rv_at = 0;
    got_cause = '0; got_epc = '0; got_pc = '0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) mret_i = 1'b0;
      if (trap_req_o) begin
        req_cnt++;
        exc_valid_i = 1'b0;
      end
      pipe_drained_i = (req_cnt > d);
      if (trap_valid_o) begin
        tv_cnt++; tv_at = n; got_cause = cause_o; got_epc = epc_o;
        mstatus_mie_i = 1'b0;
        mtvec_i = mtvec_late;
      end
      if (redirect_valid_o) begin
        rv_cnt++; rv_at = n; got_pc = redirect_pc_o;
      end
    end
    exc_valid_i = 1'b0; mstatus_mie_i = 1'b0; pipe_drained_i = 1'b0;

    chk({name, ".req_cycles"}, 32'(req_cnt), (kind == 1) ? 32'(d + 3) : 32'd0);
    chk({name, ".tv_count"}, 32'(tv_cnt), (kind == 1) ? 32'd1 : 32'd0);
    chk({name, ".rv_count"}, 32'(rv_cnt), (kind != 0) ? 32'd1 : 32'd0);
    if (kind == 1) begin
      chk({name, ".tv_at"}, 32'(tv_at), 32'(d + 2));
      chk({name, ".cause"}, got_cause, exp_cause);
      chk({name, ".epc"}, got_epc, exp_epc);
      chk({name, ".rv_at"}, 32'(rv_at), 32'(d + 3));
      chk({name, ".redirect_pc"}, got_pc, exp_pc);
    end else if (kind == 2) begin
      chk({name, ".rv_at"}, 32'(rv_at), 32'd1);
      chk({name, ".redirect_pc"}, got_pc, exp_pc);
    end
    chk({name, ".idle_cause"}, cause_o, 32'd0);
    chk({name, ".idle_pc"}, redirect_pc_o, 32'd0);
  endtask

  initial begin
    int tv_seen, rv_seen, req_seen;
    #12;
    chk("rst.mip", mip_o, 32'd0);
    chk("rst.trap_req", 32'(trap_req_o), 32'd0);
    chk("rst.trap_valid", 32'(trap_valid_o), 32'd0);
    chk("rst.redirect_valid", 32'(redirect_valid_o), 32'd0);
    chk("rst.cause", cause_o, 32'd0);
    chk("rst.epc", epc_o, 32'd0);
    chk("rst.redirect_pc", redirect_pc_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case("mei_direct", 4'b0001, 32'h800, 1'b1, 1'b0, 0, 0, 1'b0,
             32'h100, 32'h100, 0, 32'h4000, 0);
    run_case("mei_vec", 4'b0001, 32'h800, 1'b1, 1'b0, 0, 0, 1'b0,
             32'h101, 32'h101, 0, 32'h4004, 0);
    run_case("mvu_vec", 4'b1000, 32'h1_0000, 1'b1, 1'b0, 0, 0, 1'b0,
             32'h101, 32'h101, 0, 32'h4008, 1);
    run_case("exc_over_irq", 4'b0001, 32'h800, 1'b1, 1'b1, 32'd2, 32'h80, 1'b0,
             32'h101, 32'h101, 0, 32'h400C, 5);
    run_case("prio_all", 4'b0111, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 1'b0,
             32'h200, 32'h200, 0, 32'h5000, 2);
    run_case("mie_off", 4'b1111, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, 1'b0,
             32'h200, 32'h200, 0, 32'h5004, 0);
    run_case("mret", 4'b0000, 32'h0, 1'b1, 1'b0, 0, 0, 1'b1,
             32'h200, 32'h200, 32'h2000, 32'h5008, 0);
    run_case("mret_exc", 4'b0000, 32'h0, 1'b1, 1'b1, 32'd11, 32'h90, 1'b1,
             32'h300, 32'h300, 32'h2000, 32'h500C, 3);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] mt, mie_r;
      mt    = $urandom;
      mie_r = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0001_0888 & $urandom;
      run_case($sformatf("rnd%0d", k), 4'($urandom), mie_r, 1'($urandom),
               ($urandom_range(0, 3) == 0), {1'b0, 31'($urandom_range(0, 15))}, $urandom,
               ($urandom_range(0, 3) == 0), mt, mt ^ 32'h0001_0000, $urandom, $urandom,
               int'($urandom_range(0, 5)));
    end

    // reset while the FSM sits in FLUSH
    @(negedge clk);
    irq_i = 0; time_irq_i = 0; ipi_i = 0; mvu_irq_i = 0;
    mtvec_i = 32'h200; pipe_drained_i = 1'b0;
    exc_valid_i = 1'b1; exc_cause_i = 32'd5; exc_pc_i = 32'h44;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid.req_before", 32'(trap_req_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.trap_req", 32'(trap_req_o), 32'd0);
    chk("rstmid.trap_valid", 32'(trap_valid_o), 32'd0);
    chk("rstmid.redirect_valid", 32'(redirect_valid_o), 32'd0);
    chk("rstmid.redirect_pc", redirect_pc_o, 32'd0);
    chk("rstmid.mip", mip_o, 32'd0);
    exc_valid_i = 1'b0; pipe_drained_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tv_seen = 0; rv_seen = 0; req_seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (trap_valid_o) tv_seen++;
      if (redirect_valid_o) rv_seen++;
      if (trap_req_o) req_seen++;
    end
    chk("rstmid.no_tv_after", 32'(tv_seen), 32'd0);
    chk("rstmid.no_rv_after", 32'(rv_seen), 32'd0);
    chk("rstmid.no_req_after", 32'(req_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
